delay_line_var: RTL
===================

Name: delay_line_var

Overview:
- Runtime-programmable multi-channel delay line. Generalises the fixed shift-register delay with per-sample valid tracking, a clock enable (stall), a delay that can be reloaded at run time, flush-on-reload and a primed indicator.
- Sits in audio/sample datapaths to align streams of differing pipeline latency.
- Storage is a circular buffer indexed by pointers; it is not a full-width shift register.

Parameters:
- DATA_WIDTH, 16, bits per channel sample.
- CHANNELS, 2, parallel channels sharing one delay setting.
- MAX_DELAY, 64, largest supported delay in enabled cycles; must be ≥2.
- DEFAULT_DELAY, 20, active delay after reset; must be in 1..MAX_DELAY.
- DLY_W, clog2(MAX_DELAY)+1, derived width of delay values; do not override.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset_n  in  1  synchronous, active-low reset.
- en  in  1  clock enable; 0 means full stall.
- delay_load  in  1  single-cycle strobe; latches delay_sel.
- delay_sel  in  DLY_W  requested delay in enabled cycles.
- valid_in  in  1  qualifies data_in.
- data_in  in  CHANNELS*DATA_WIDTH  packed samples; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- valid_out  out  1  delayed valid_in.
- data_out  out  CHANNELS*DATA_WIDTH  delayed data_in.
- delay_active  out  DLY_W  currently applied delay D.
- primed  out  1  high once D enabled cycles have elapsed since reset or the last load.

Behaviour:
- Reset (reset_n=0 at posedge) has priority over all other inputs. It sets:
  - valid_out=0, data_out=0, primed=0, delay_active=DEFAULT_DELAY;
  - write pointer=0, fill counter=0;
  - all stored valid bits cleared.
  - Stored data contents are don't-care.
- Core rule, with en=1 every cycle and no load:
  - valid_in/data_in sampled at posedge t appear on valid_out/data_out after posedge t+D−1, i.e. visible during cycle t+D.
  - D=1 behaves as a single register stage.
- Enabled cycles only: each en=1 posedge writes {valid_in,data_in} into the buffer and advances the write pointer modulo MAX_DELAY.
  - Read address = wr_ptr − (D−1) mod MAX_DELAY.
  - Outputs are registered.
  - D=1 must bypass the buffer, taking the output from the input register path.
- en=0: pointers, buffer, outputs, fill counter and primed all hold. Latency is counted in enabled cycles only.
- Pointer wrap-around from MAX_DELAY−1 to 0 must be seamless, with no dropped or repeated sample.
- delay_load=1 at a posedge with reset_n=1 takes effect regardless of en:
  - New delay D' = clamp(delay_sel): 0 maps to 1; values above MAX_DELAY map to MAX_DELAY.
  - delay_active <= D'.
  - All stored valid bits are cleared (flush); valid_out <= 0; data_out holds its value.
  - Fill counter <= 0; primed <= 0.
  - The input sampled in the load cycle is discarded: it is written with valid=0, and the pointer advances only if en=1.
- After a load, the first valid output is the first valid input presented after the load cycle, delayed by D'.
- primed:
  - The fill counter increments on each enabled cycle, saturating at D.
  - primed=1 when counter==D. It stays high until the next reset or load.
- Flushed or stale slots emit valid_out=0. data_out under valid_out=0 is don't-care, except for the hold on load.
- Back-to-back loads: the last one wins, and each load restarts the flush/priming sequence.

Decomposition:
- Shared header delay_defs.vh holds:
  - the clog2 constant function;
  - a macro for the channel slice index.
- One natural sub-module, delay_ptr_ctrl, contains:
  - write and read pointers with modular arithmetic;
  - the delay clamp register;
  - the fill counter and primed flag.
- The top level holds the data/valid storage, the D=1 bypass and the output registers.

Test Plan:
1. Reset, then stream with en=1: D=20, ramp valid_in=1 with data 1,2,3,…. Required: primed rises after 20 enabled cycles; first valid_out carries data 1 exactly 20 cycles after input 1; strict sequence thereafter.
2. Wrap-around: MAX_DELAY=64, load D=64, stream 200 samples. Required: output equals input 64 cycles earlier across three pointer wraps, with no gap.
3. Stall: D=5, toggle en with pattern 1,0,0,1,1,0,…. Required: outputs hold while en=0; each sample emerges after exactly 5 enabled cycles.
4. Reload mid-stream: D=10 streaming, pulse delay_load with delay_sel=3. Required: valid_out=0 on the next cycle; primed=0; first post-load input appears 3 enabled cycles later; no pre-load sample ever appears.
5. Clamp and boundaries:
   - delay_sel=0: delay_active=1 and the output equals the input one cycle later.
   - delay_sel=100 (MAX_DELAY=64): delay_active=64.
   - Concurrent delay_load and reset_n=0: reset wins, delay_active=DEFAULT_DELAY.
6. Multi-channel integrity: CHANNELS=2, ch0 ramps up and ch1 ramps down, D=7, with random valid_in gaps. Required: each channel is delayed independently and exactly, and valid gaps are preserved position for position.

Source files
------------

// File: rtl/delay_line_var_pkg.sv
// Shared helpers for the variable delay line: width math and channel slicing.
package delay_line_var_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) r++;
        return r;
    endfunction

    // LSB of channel k inside the packed sample bus.
    function automatic int ch_lsb(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/delay_ptr_ctrl.sv
// Pointer, delay and priming control for the circular-buffer delay line.
module delay_ptr_ctrl
    import delay_line_var_pkg::*;
#(
    parameter int MAX_DELAY     = 64,
    parameter int DEFAULT_DELAY = 20,
    parameter int DLY_W         = clog2(MAX_DELAY) + 1,
    parameter int AW            = clog2(MAX_DELAY)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             delay_load,
    input  logic [DLY_W-1:0] delay_sel,
    output logic [AW-1:0]    wr_ptr,
    output logic [AW-1:0]    rd_ptr,
    output logic [DLY_W-1:0] delay_active,
    output logic             primed
);
    localparam logic [DLY_W-1:0] MAX_D = DLY_W'(MAX_DELAY);
    localparam logic [DLY_W-1:0] DEF_D = DLY_W'(DEFAULT_DELAY);
    localparam logic [AW-1:0]    LAST  = AW'(MAX_DELAY - 1);
    localparam logic [DLY_W:0]   MAX_W = (DLY_W+1)'(MAX_DELAY);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic [DLY_W-1:0] fill_q, fill_d;
    logic             primed_q, primed_d;
    logic [DLY_W:0]   wr_ext, back, rd_wide;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        dly_d    = dly_q;
        fill_d   = fill_q;
        if (en)
            wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + AW'(1);
        if (delay_load) begin
            if (delay_sel == '0)
                dly_d = DLY_W'(1);
            else if (delay_sel > MAX_D)
                dly_d = MAX_D;
            else
                dly_d = delay_sel;
            fill_d = '0;
        end else if (en && fill_q != dly_q) begin
            fill_d = fill_q + DLY_W'(1);
        end
        primed_d = (fill_d == dly_d);
    end

    // Read slot lags the write slot by D-1, wrapped into 0..MAX_DELAY-1.
    always_comb begin
        wr_ext  = (DLY_W+1)'(wr_ptr_q);
        back    = (DLY_W+1)'(dly_q) - (DLY_W+1)'(1);
        rd_wide = (wr_ext >= back) ? wr_ext - back : wr_ext + MAX_W - back;
        rd_ptr  = AW'(rd_wide);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            dly_q    <= DEF_D;
            fill_q   <= '0;
            primed_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            dly_q    <= dly_d;
            fill_q   <= fill_d;
            primed_q <= primed_d;
        end
    end

    assign wr_ptr       = wr_ptr_q;
    assign delay_active = dly_q;
    assign primed       = primed_q;

endmodule

// File: rtl/delay_line_var.sv
// Runtime-programmable multi-channel delay line over a circular buffer,
// with stall, flush-on-reload and a primed indicator.
module delay_line_var
    import delay_line_var_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int CHANNELS      = 2,
    parameter int MAX_DELAY     = 64,
    parameter int DEFAULT_DELAY = 20,
    parameter int DLY_W         = clog2(MAX_DELAY) + 1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           en,
    input  logic                           delay_load,
    input  logic [DLY_W-1:0]               delay_sel,
    input  logic                           valid_in,
    input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
    output logic                           valid_out,
    output logic [CHANNELS*DATA_WIDTH-1:0] data_out,
    output logic [DLY_W-1:0]               delay_active,
    output logic                           primed
);
    localparam int AW = clog2(MAX_DELAY);
    localparam int DW = CHANNELS * DATA_WIDTH;

    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [DW-1:0]        rd_data;
    logic [MAX_DELAY-1:0] vmem_q, vmem_d;
    logic                 valid_out_q, valid_out_d;
    logic [DW-1:0]        data_out_q, data_out_d;
    logic                 bypass;

    delay_ptr_ctrl #(
        .MAX_DELAY    (MAX_DELAY),
        .DEFAULT_DELAY(DEFAULT_DELAY),
        .DLY_W        (DLY_W),
        .AW           (AW)
    ) u_ptr (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .delay_load  (delay_load),
        .delay_sel   (delay_sel),
        .wr_ptr      (wr_ptr),
        .rd_ptr      (rd_ptr),
        .delay_active(delay_active),
        .primed      (primed)
    );

    // Sample storage carries no reset; validity lives in vmem_q.
    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic [DATA_WIDTH-1:0] mem_q [MAX_DELAY];

        always_ff @(posedge clk) begin
            if (reset_n && en)
                mem_q[wr_ptr] <= data_in[ch_lsb(k, DATA_WIDTH) +: DATA_WIDTH];
        end

        assign rd_data[ch_lsb(k, DATA_WIDTH) +: DATA_WIDTH] = mem_q[rd_ptr];
    end

    assign bypass = (delay_active == DLY_W'(1));

    always_comb begin
        vmem_d      = vmem_q;
        valid_out_d = valid_out_q;
        data_out_d  = data_out_q;
        if (delay_load) begin
            // Flush drops every stored sample, including this cycle's input.
            vmem_d      = '0;
            valid_out_d = 1'b0;
        end else if (en) begin
            vmem_d[wr_ptr] = valid_in;
            if (bypass) begin
                valid_out_d = valid_in;
                data_out_d  = data_in;
            end else begin
                valid_out_d = vmem_q[rd_ptr];
                data_out_d  = rd_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vmem_q      <= '0;
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
        end else begin
            vmem_q      <= vmem_d;
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
        end
    end

    assign valid_out = valid_out_q;
    assign data_out  = data_out_q;

endmodule
